onehot_decoder_pipe: RTL and testbench

Registered binary-to-onehot decoder with valid/ready handshakes on both sides. It turns a binary index into an OUTPUT_W-bit onehot vector and flags indices that have no onehot bit. A two-entry skid buffer keeps full throughput while every control output stays registered. It is the transmit-side counterpart of the onehot encoder: it drives onehot grant/select vectors from binary indices produced by arbiters, schedulers and FIFO pointers.

---
 rtl/onehot_decoder_pipe_pkg.sv | 14 +
 rtl/onehot_decoder_pipe_dec.sv | 24 ++
 rtl/onehot_decoder_pipe.sv | 132 +++++++++++++
 tb/tb_onehot_decoder_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pipe_pkg.sv
// Shared definitions for the onehot decoder pipe: skid-buffer state encoding
// and the width-legality check also used by onehot_encoder.
package onehot_decoder_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // A onehot vector needs at least one bit and can use every index code at most once.
  function automatic bit onehot_width_ok(input int in_w, input int out_w);
    return (in_w >= 1) && (in_w <= 30) && (out_w >= 1) && (out_w <= (1 << in_w));
  endfunction

endpackage

// File: rtl/onehot_decoder_pipe_dec.sv
// Purely combinational binary-to-onehot decoder with an out-of-range flag.
module onehot_decoder
  import onehot_decoder_pipe_pkg::*;
#(
  parameter int INPUT_W  = 3,
  parameter int OUTPUT_W = 8
) (
  input  logic [INPUT_W-1:0]  i_bin,
  output logic [OUTPUT_W-1:0] o_oh,
  output logic                o_oor
);

  if (!onehot_width_ok(INPUT_W, OUTPUT_W)) begin : g_bad_width
    $error("onehot_decoder: illegal INPUT_W/OUTPUT_W combination");
  end

  for (genvar k = 0; k < OUTPUT_W; k++) begin : g_bit
    assign o_oh[k] = (i_bin == INPUT_W'(k));
  end

  // One extra bit so OUTPUT_W == 2**INPUT_W is representable in the compare.
  assign o_oor = ({1'b0, i_bin} >= (INPUT_W + 1)'(OUTPUT_W));

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-onehot decoder with valid/ready on both sides and a
// two-entry skid buffer so every control output stays registered at full rate.
module onehot_decoder_pipe
  import onehot_decoder_pipe_pkg::*;
#(
  parameter int INPUT_W  = 3,
  parameter int OUTPUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INPUT_W-1:0]  bin_i,
  input  logic                bin_vld_i,
  output logic                bin_rdy_o,
  output logic [OUTPUT_W-1:0] oh_o,
  output logic                oor_o,
  output logic                oh_vld_o,
  input  logic                oh_rdy_i
);

  logic [1:0]          r_state;
  logic                r_rdy;
  logic                r_vld;
  logic [OUTPUT_W-1:0] r_main_oh;
  logic                r_main_oor;
  logic [OUTPUT_W-1:0] r_skid_oh;
  logic                r_skid_oor;

  logic [1:0]          w_state_nxt;
  logic [OUTPUT_W-1:0] w_main_oh_nxt;
  logic                w_main_oor_nxt;
  logic [OUTPUT_W-1:0] w_skid_oh_nxt;
  logic                w_skid_oor_nxt;
  logic [OUTPUT_W-1:0] w_dec_oh;
  logic                w_dec_oor;
  logic                w_in_xfer;
  logic                w_out_xfer;

  onehot_decoder #(
    .INPUT_W  (INPUT_W),
    .OUTPUT_W (OUTPUT_W)
  ) u_dec (
    .i_bin (bin_i),
    .o_oh  (w_dec_oh),
    .o_oor (w_dec_oor)
  );

  assign w_in_xfer  = bin_vld_i & r_rdy;
  assign w_out_xfer = r_vld & oh_rdy_i;

  // Next state and next contents of the main and skid entries.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_oh_nxt  = r_main_oh;
    w_main_oor_nxt = r_main_oor;
    w_skid_oh_nxt  = r_skid_oh;
    w_skid_oor_nxt = r_skid_oor;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt    = ST_ONE;
          w_main_oh_nxt  = w_dec_oh;
          w_main_oor_nxt = w_dec_oor;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_state_nxt    = ST_ONE;
          w_main_oh_nxt  = w_dec_oh;
          w_main_oor_nxt = w_dec_oor;
        end else if (w_in_xfer) begin
          w_state_nxt    = ST_TWO;
          w_skid_oh_nxt  = w_dec_oh;
          w_skid_oor_nxt = w_dec_oor;
        end else if (w_out_xfer) begin
          w_state_nxt    = ST_EMPTY;
          w_main_oh_nxt  = {OUTPUT_W{1'b0}};
          w_main_oor_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        // Ready is low here, so only the drain of main can happen.
        if (w_out_xfer) begin
          w_state_nxt    = ST_ONE;
          w_main_oh_nxt  = r_skid_oh;
          w_main_oor_nxt = r_skid_oor;
          w_skid_oh_nxt  = {OUTPUT_W{1'b0}};
          w_skid_oor_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_TWO;
        end
      end
      default: begin
        w_state_nxt    = ST_EMPTY;
        w_main_oh_nxt  = {OUTPUT_W{1'b0}};
        w_main_oor_nxt = 1'b0;
        w_skid_oh_nxt  = {OUTPUT_W{1'b0}};
        w_skid_oor_nxt = 1'b0;
      end
    endcase
  end

  // State, storage and registered handshake outputs; ready stays low while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_rdy      <= 1'b0;
      r_vld      <= 1'b0;
      r_main_oh  <= {OUTPUT_W{1'b0}};
      r_main_oor <= 1'b0;
      r_skid_oh  <= {OUTPUT_W{1'b0}};
      r_skid_oor <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rdy      <= (w_state_nxt != ST_TWO);
      r_vld      <= (w_state_nxt != ST_EMPTY);
      r_main_oh  <= w_main_oh_nxt;
      r_main_oor <= w_main_oor_nxt;
      r_skid_oh  <= w_skid_oh_nxt;
      r_skid_oor <= w_skid_oor_nxt;
    end
  end

  assign bin_rdy_o = r_rdy;
  assign oh_vld_o  = r_vld;
  assign oh_o      = r_main_oh;
  assign oor_o     = r_main_oor;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench: vector tables, backpressure and reset sequences, and a
// randomized run against a queue-based reference model.
module tb_onehot_decoder_pipe;

  logic       clk;
  logic       rst_n;
  logic [2:0] bin8, bin5;
  logic       vld8, vld5, rdy8, rdy5;
  logic [7:0] oh8;
  logic [4:0] oh5;
  logic       oor8, oor5, ovld8, ovld5, ordy8, ordy5;

  int n_err;
  int n_checks;

  typedef struct {
    logic [2:0] bin;
    logic [7:0] oh;
    logic       oor;
  } vec_t;

  vec_t tbl[12];

  onehot_decoder_pipe #(.INPUT_W(3), .OUTPUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bin_i(bin8), .bin_vld_i(vld8), .bin_rdy_o(rdy8),
    .oh_o(oh8), .oor_o(oor8), .oh_vld_o(ovld8), .oh_rdy_i(ordy8)
  );

  onehot_decoder_pipe #(.INPUT_W(3), .OUTPUT_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bin_i(bin5), .bin_vld_i(vld5), .bin_rdy_o(rdy5),
    .oh_o(oh5), .oor_o(oor5), .oh_vld_o(ovld5), .oh_rdy_i(ordy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Back-to-back stream of table entries [first..last] into one DUT, oh_rdy high.
  task automatic stream(input int first, input int last, input bit use5);
    for (int i = first; i <= last; i++) begin
      if (use5) begin
        vld5 = 1'b1; bin5 = tbl[i].bin;
        chk("stream5_rdy", 32'(rdy5), 32'd1);
      end else begin
        vld8 = 1'b1; bin8 = tbl[i].bin;
        chk("stream8_rdy", 32'(rdy8), 32'd1);
      end
      tick();
      if (use5) begin
        chk("stream5_oh", 32'(oh5), 32'(tbl[i].oh));
        chk("stream5_oor", 32'(oor5), 32'(tbl[i].oor));
        chk("stream5_vld", 32'(ovld5), 32'd1);
      end else begin
        chk("stream8_oh", 32'(oh8), 32'(tbl[i].oh));
        chk("stream8_oor", 32'(oor8), 32'(tbl[i].oor));
        chk("stream8_vld", 32'(ovld8), 32'd1);
      end
    end
    vld8 = 1'b0;
    vld5 = 1'b0;
    tick();
    chk("stream_drain_vld", 32'(use5 ? ovld5 : ovld8), 32'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_oh;
  logic [7:0] prev_oh;
  bit         stalled, in_x, out_x;

  initial begin
    n_err = 0;
    n_checks = 0;
    tbl[0]  = '{3'd0, 8'h01, 1'b0};
    tbl[1]  = '{3'd1, 8'h02, 1'b0};
    tbl[2]  = '{3'd2, 8'h04, 1'b0};
    tbl[3]  = '{3'd3, 8'h08, 1'b0};
    tbl[4]  = '{3'd4, 8'h10, 1'b0};
    tbl[5]  = '{3'd5, 8'h20, 1'b0};
    tbl[6]  = '{3'd6, 8'h40, 1'b0};
    tbl[7]  = '{3'd7, 8'h80, 1'b0};
    tbl[8]  = '{3'd5, 8'h00, 1'b1};
    tbl[9]  = '{3'd6, 8'h00, 1'b1};
    tbl[10] = '{3'd7, 8'h00, 1'b1};
    tbl[11] = '{3'd4, 8'h10, 1'b0};

    rst_n = 1'b0;
    bin8 = 3'd3; vld8 = 1'b1; ordy8 = 1'b1;
    bin5 = 3'd3; vld5 = 1'b1; ordy5 = 1'b1;

    // Reset held three cycles with a valid index offered.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_rdy", 32'(rdy8), 32'd0);
      chk("rst_vld", 32'(ovld8), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    vld8 = 1'b0; vld5 = 1'b0;
    chk("post_rst_rdy", 32'(rdy8), 32'd1);
    chk("post_rst_vld", 32'(ovld8), 32'd0);
    chk("post_rst_oh", 32'(oh8), 32'h00);
    tick();
    chk("no_accept_in_rst", 32'(ovld8), 32'd0);

    stream(0, 7, 1'b0);
    stream(8, 11, 1'b1);

    // Backpressure: 1,2,3 with oh_rdy dropped after the first accept.
    vld8 = 1'b1; bin8 = 3'd1; ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0; bin8 = 3'd2;
    chk("bp_first_oh", 32'(oh8), 32'h02);
    chk("bp_rdy_one", 32'(rdy8), 32'd1);
    tick();
    bin8 = 3'd3;
    for (int c = 0; c < 3; c++) begin
      chk("bp_rdy_low", 32'(rdy8), 32'd0);
      chk("bp_hold_oh", 32'(oh8), 32'h02);
      chk("bp_hold_vld", 32'(ovld8), 32'd1);
      tick();
    end
    ordy8 = 1'b1;
    tick();
    chk("bp_out2", 32'(oh8), 32'h04);
    chk("bp_rdy_back", 32'(rdy8), 32'd1);
    tick();
    vld8 = 1'b0;
    chk("bp_out3", 32'(oh8), 32'h08);
    tick();
    chk("bp_drained", 32'(ovld8), 32'd0);

    // Randomized traffic against a two-deep queue model.
    q.delete();
    stalled = 1'b0;
    prev_oh = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      vld8  = ($urandom_range(0, 3) != 0);
      bin8  = 3'($urandom_range(0, 7));
      ordy8 = ($urandom_range(0, 2) != 0);
      chk("rnd_vld", 32'(ovld8), 32'(q.size() != 0));
      chk("rnd_rdy", 32'(rdy8), 32'(q.size() < 2));
      if (q.size() != 0) begin
        chk("rnd_oh", 32'(oh8), 32'(q[0]));
        chk("rnd_oor", 32'(oor8), 32'd0);
      end
      if (stalled) begin
        chk("rnd_hold", 32'(oh8), 32'(prev_oh));
      end
      in_x    = vld8 & rdy8;
      out_x   = ovld8 & ordy8;
      stalled = ovld8 & !ordy8;
      prev_oh = oh8;
      exp_oh  = 8'h01 << bin8;
      tick();
      if (out_x && q.size() != 0) begin
        void'(q.pop_front());
      end
      if (in_x) begin
        q.push_back(exp_oh);
      end
    end
    vld8 = 1'b0; ordy8 = 1'b1;
    tick(); tick(); tick();
    chk("rnd_drain", 32'(ovld8), 32'd0);

    // Reset while both entries are full.
    ordy8 = 1'b0; vld8 = 1'b1; bin8 = 3'd1;
    tick();
    bin8 = 3'd2;
    tick();
    chk("mid_two_rdy", 32'(rdy8), 32'd0);
    vld8 = 1'b0; ordy8 = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_vld", 32'(ovld8), 32'd0);
    chk("mid_rst_oh", 32'(oh8), 32'h00);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_rdy", 32'(rdy8), 32'd1);
    chk("mid_rel_vld", 32'(ovld8), 32'd0);
    vld8 = 1'b1; bin8 = 3'd5;
    tick();
    vld8 = 1'b0;
    chk("mid_next_oh", 32'(oh8), 32'h20);
    chk("mid_next_vld", 32'(ovld8), 32'd1);
    tick();
    chk("mid_final_vld", 32'(ovld8), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
